// File: rtl/uart_tx.sv
// UART transmitter with a single-entry holding register, 16x oversampled bit timing
// and a sticky overflow flag for writes that arrive while the holding register is full.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tick,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 err_clear,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 hold_full,
  output logic                 tx_done_tick,
  output logic                 overflow_err
);

  localparam int TICK_MAX = (SB_TICKS - 1 > 15) ? (SB_TICKS - 1) : 15;
  localparam int TW       = $clog2(TICK_MAX + 1);
  localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_BIT_LAST  = TW'(15);
  localparam logic [TW-1:0] TICK_STOP_LAST = TW'(SB_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST       = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic [TW-1:0]         r_tick,  w_tick;
  logic [BW-1:0]         r_bit,   w_bit;
  logic [DATA_BITS-1:0]  r_shift, w_shift;
  logic [DATA_BITS-1:0]  r_hold,  w_hold;
  logic                  r_hold_full, w_hold_full;
  logic                  r_tx,   w_tx;
  logic                  r_done, w_done;
  logic                  r_ovf,  w_ovf;
  logic                  w_drain;
  logic [DATA_BITS-1:0]  w_shift_r1;

  assign w_shift_r1 = r_shift >> 1;

  // State and datapath registers; tx is driven with the value of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tick      <= {TW{1'b0}};
      r_bit       <= {BW{1'b0}};
      r_shift     <= {DATA_BITS{1'b0}};
      r_hold      <= {DATA_BITS{1'b0}};
      r_hold_full <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tick      <= w_tick;
      r_bit       <= w_bit;
      r_shift     <= w_shift;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_tx        <= w_tx;
      r_done      <= w_done;
      r_ovf       <= w_ovf;
    end
  end

  // Next-state logic for the frame sequencer, holding register and error flag.
  always_comb begin
    w_state     = r_state;
    w_tick      = r_tick;
    w_bit       = r_bit;
    w_shift     = r_shift;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_tx        = r_tx;
    w_done      = 1'b0;
    w_ovf       = r_ovf;
    w_drain     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx   = 1'b1;
        w_tick = {TW{1'b0}};
        if (r_hold_full) begin
          w_drain     = 1'b1;
          w_shift     = r_hold;
          w_hold_full = 1'b0;
          w_bit       = {BW{1'b0}};
          w_state     = ST_START;
          w_tx        = 1'b0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_tick == TICK_BIT_LAST) begin
            w_state = ST_DATA;
            w_tick  = {TW{1'b0}};
            w_bit   = {BW{1'b0}};
            w_tx    = r_shift[0];
          end else begin
            w_tick = r_tick + TW'(1);
          end
        end else begin
          w_tick = r_tick;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_tick == TICK_BIT_LAST) begin
            w_tick  = {TW{1'b0}};
            w_shift = w_shift_r1;
            if (r_bit == BIT_LAST) begin
              w_state = ST_STOP;
              w_tx    = 1'b1;
            end else begin
              w_bit = r_bit + BW'(1);
              w_tx  = w_shift_r1[0];
            end
          end else begin
            w_tick = r_tick + TW'(1);
          end
        end else begin
          w_tick = r_tick;
        end
      end
      ST_STOP: begin
        w_tx = 1'b1;
        if (s_tick) begin
          if (r_tick == TICK_STOP_LAST) begin
            w_state = ST_IDLE;
            w_tick  = {TW{1'b0}};
            w_done  = 1'b1;
          end else begin
            w_tick = r_tick + TW'(1);
          end
        end else begin
          w_tick = r_tick;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_tick  = {TW{1'b0}};
        w_tx    = 1'b1;
      end
    endcase

    // A write in the drain cycle refills the holding register instead of overflowing.
    if (wr_en) begin
      if (!r_hold_full || w_drain) begin
        w_hold      = din;
        w_hold_full = 1'b1;
      end else begin
        w_hold = r_hold;
      end
    end else begin
      w_hold = w_hold;
    end

    if (wr_en && r_hold_full && !w_drain) begin
      w_ovf = 1'b1;
    end else if (err_clear) begin
      w_ovf = 1'b0;
    end else begin
      w_ovf = r_ovf;
    end
  end

  assign tx           = r_tx;
  assign tx_busy      = (r_state != ST_IDLE);
  assign hold_full    = r_hold_full;
  assign tx_done_tick = r_done;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one 8N1 instance and one with a two-stop-bit period.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n, s_tick, wr_en, err_clear, wr_en2;
  logic [7:0] din, din2;
  logic       tx, tx_busy, hold_full, tx_done_tick, overflow_err;
  logic       tx2, tx_busy2, hold_full2, tx_done_tick2, overflow_err2;

  int errors = 0;
  int checks = 0;
  bit tick_en = 1'b0;
  int tick_phase = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .wr_en(wr_en), .din(din),
    .err_clear(err_clear), .tx(tx), .tx_busy(tx_busy), .hold_full(hold_full),
    .tx_done_tick(tx_done_tick), .overflow_err(overflow_err)
  );

  uart_tx #(.DATA_BITS(8), .SB_TICKS(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .wr_en(wr_en2), .din(din2),
    .err_clear(err_clear), .tx(tx2), .tx_busy(tx_busy2), .hold_full(hold_full2),
    .tx_done_tick(tx_done_tick2), .overflow_err(overflow_err2)
  );

  // s_tick: one clk wide, every 4th clk, changed on the falling edge
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_phase = (tick_phase + 1) % 4;
      s_tick = tick_en && (tick_phase == 0);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts in the first start-bit cycle (or waits for it); samples each bit mid-way by s_tick count.
  task automatic capture_frame(output logic [9:0] bits, output int ticks,
                               output int data_clks, output bit busy_ok, output bit timeout);
    int n;
    int c16;
    bits = 10'h000; ticks = 0; data_clks = 0; busy_ok = 1'b1; timeout = 1'b0; n = 0; c16 = 0;
    while (tx !== 1'b0 && n < 2000) begin step(); n++; end
    if (tx !== 1'b0) begin
      timeout = 1'b1;
      return;
    end
    n = 0;
    while (tx_done_tick !== 1'b1 && n < 3000) begin
      if (tx_busy !== 1'b1) busy_ok = 1'b0;
      step(); n++;
      if (s_tick) begin
        ticks++;
        if ((ticks % 16) == 8 && (ticks / 16) < 10) bits[ticks/16] = tx;
        if (ticks == 16) c16 = n;
        if (ticks == 144) data_clks = n - c16;
      end
    end
    if (tx_done_tick !== 1'b1) timeout = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_en = 1'b0; din = 8'h00; err_clear = 1'b0; wr_en2 = 1'b0; din2 = 8'h00;
    repeat (3) step();
    checks++;
    if ({tx, tx_busy, hold_full, tx_done_tick, overflow_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_dut: got %b expected 10000", {tx, tx_busy, hold_full, tx_done_tick, overflow_err});
    end
    checks++;
    if ({tx2, tx_busy2, hold_full2, tx_done_tick2, overflow_err2} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_dut2: got %b expected 10000", {tx2, tx_busy2, hold_full2, tx_done_tick2, overflow_err2});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_byte;
    logic [9:0] bits; int ticks, dclk; bit busy_ok, tmo;
    tick_en = 1'b1;
    din = 8'hA5; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++;
    if (hold_full !== 1'b1) begin errors++; $display("FAIL single_hold: got %b expected 1", hold_full); end
    capture_frame(bits, ticks, dclk, busy_ok, tmo);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", tmo); end
    checks++;
    if (bits !== 10'b1_1010_0101_0) begin errors++; $display("FAIL single_bits: got %b expected 1101001010", bits); end
    checks++;
    if (ticks !== 160) begin errors++; $display("FAIL single_ticks: got %0d expected 160", ticks); end
    checks++;
    if (dclk !== 512) begin errors++; $display("FAIL single_data_clks: got %0d expected 512", dclk); end
    checks++;
    if (busy_ok !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy_ok); end
    step();
    checks++;
    if ({tx, tx_busy, tx_done_tick} !== 3'b100) begin errors++; $display("FAIL single_after: got %b expected 100", {tx, tx_busy, tx_done_tick}); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits; int ticks, dclk; bit busy_ok, tmo;
    tick_en = 1'b0;
    din = 8'h55; wr_en = 1'b1; step();
    wr_en = 1'b0; step();
    din = 8'h0F; wr_en = 1'b1; step();
    wr_en = 1'b0;
    checks++;
    if ({hold_full, overflow_err} !== 2'b10) begin errors++; $display("FAIL b2b_hold: got %b expected 10", {hold_full, overflow_err}); end
    tick_en = 1'b1;
    capture_frame(bits, ticks, dclk, busy_ok, tmo);
    checks++;
    if (bits !== {1'b1, 8'h55, 1'b0} || tmo) begin errors++; $display("FAIL b2b_frame1: got %b expected %b", bits, {1'b1, 8'h55, 1'b0}); end
    checks++;
    if ({tx, hold_full} !== 2'b11) begin errors++; $display("FAIL b2b_end1: got %b expected 11", {tx, hold_full}); end
    step();
    checks++;
    if ({tx, hold_full, tx_done_tick} !== 3'b000) begin errors++; $display("FAIL b2b_gap: got %b expected 000", {tx, hold_full, tx_done_tick}); end
    capture_frame(bits, ticks, dclk, busy_ok, tmo);
    checks++;
    if (bits !== {1'b1, 8'h0F, 1'b0} || ticks !== 160) begin errors++; $display("FAIL b2b_frame2: got %b/%0d expected %b/160", bits, ticks, {1'b1, 8'h0F, 1'b0}); end
    checks++;
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", overflow_err); end
  endtask

  task automatic test_overflow;
    logic [9:0] bits; int ticks, dclk; bit busy_ok, tmo; int n;
    tick_en = 1'b0;
    din = 8'h11; wr_en = 1'b1; step();
    wr_en = 1'b0; step();
    din = 8'h22; wr_en = 1'b1; step();
    din = 8'h33; step();
    wr_en = 1'b0;
    checks++;
    if ({overflow_err, hold_full} !== 2'b11) begin errors++; $display("FAIL ovf_set: got %b expected 11", {overflow_err, hold_full}); end
    tick_en = 1'b1;
    capture_frame(bits, ticks, dclk, busy_ok, tmo);
    checks++;
    if (bits !== {1'b1, 8'h11, 1'b0} || tmo) begin errors++; $display("FAIL ovf_frame1: got %b expected %b", bits, {1'b1, 8'h11, 1'b0}); end
    step();
    capture_frame(bits, ticks, dclk, busy_ok, tmo);
    checks++;
    if (bits !== {1'b1, 8'h22, 1'b0} || tmo) begin errors++; $display("FAIL ovf_frame2: got %b expected %b", bits, {1'b1, 8'h22, 1'b0}); end
    repeat (200) step();
    checks++;
    if ({tx, tx_busy, hold_full, overflow_err} !== 4'b1001) begin errors++; $display("FAIL ovf_lost: got %b expected 1001", {tx, tx_busy, hold_full, overflow_err}); end
    err_clear = 1'b1; step();
    err_clear = 1'b0;
    checks++;
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow_err); end
    tick_en = 1'b0;
    din = 8'h44; wr_en = 1'b1; step();
    wr_en = 1'b0; step();
    din = 8'h45; wr_en = 1'b1; step();
    din = 8'h46; err_clear = 1'b1; step();
    wr_en = 1'b0; err_clear = 1'b0;
    checks++;
    if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow_err); end
    tick_en = 1'b1;
    n = 0;
    while ((tx_busy !== 1'b0 || hold_full !== 1'b0) && n < 4000) begin step(); n++; end
    checks++;
    if ({tx_busy, hold_full} !== 2'b00) begin errors++; $display("FAIL ovf_drain_timeout: got %b expected 00", {tx_busy, hold_full}); end
    err_clear = 1'b1; step();
    err_clear = 1'b0;
  endtask

  task automatic test_drain_collision;
    logic [9:0] bits; int ticks, dclk; bit busy_ok, tmo;
    tick_en = 1'b0;
    din = 8'h3C; wr_en = 1'b1; step();
    din = 8'hC3; step();
    wr_en = 1'b0;
    checks++;
    if ({hold_full, overflow_err, tx, tx_busy} !== 4'b1001) begin errors++; $display("FAIL drain_load: got %b expected 1001", {hold_full, overflow_err, tx, tx_busy}); end
    tick_en = 1'b1;
    capture_frame(bits, ticks, dclk, busy_ok, tmo);
    checks++;
    if (bits !== {1'b1, 8'h3C, 1'b0} || tmo) begin errors++; $display("FAIL drain_frame1: got %b expected %b", bits, {1'b1, 8'h3C, 1'b0}); end
    step();
    capture_frame(bits, ticks, dclk, busy_ok, tmo);
    checks++;
    if (bits !== {1'b1, 8'hC3, 1'b0} || tmo) begin errors++; $display("FAIL drain_frame2: got %b expected %b", bits, {1'b1, 8'hC3, 1'b0}); end
    step();
    checks++;
    if ({hold_full, overflow_err} !== 2'b00) begin errors++; $display("FAIL drain_end: got %b expected 00", {hold_full, overflow_err}); end
  endtask

  task automatic test_two_stop;
    int ticks, stop_at, n; logic [8:0] bits;
    tick_en = 1'b0;
    din2 = 8'h67; wr_en2 = 1'b1; step();
    wr_en2 = 1'b0; step();
    checks++;
    if (tx2 !== 1'b0) begin errors++; $display("FAIL stop2_start: got %b expected 0", tx2); end
    tick_en = 1'b1;
    ticks = 0; stop_at = -1; n = 0; bits = 9'h000;
    while (tx_done_tick2 !== 1'b1 && n < 3000) begin
      step(); n++;
      if (s_tick) begin
        ticks++;
        if ((ticks % 16) == 8 && (ticks / 16) < 9) bits[ticks/16] = tx2;
      end
      if (tx2 === 1'b1 && ticks >= 128 && stop_at < 0) stop_at = ticks;
    end
    checks++;
    if (bits !== {8'h67, 1'b0}) begin errors++; $display("FAIL stop2_bits: got %b expected %b", bits, {8'h67, 1'b0}); end
    checks++;
    if (ticks !== 176) begin errors++; $display("FAIL stop2_frame_ticks: got %0d expected 176", ticks); end
    checks++;
    if (ticks - stop_at !== 32) begin errors++; $display("FAIL stop2_stop_ticks: got %0d expected 32", ticks - stop_at); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] bits; int ticks, dclk, n; bit busy_ok, tmo;
    tick_en = 1'b0;
    din = 8'h96; wr_en = 1'b1; step();
    wr_en = 1'b0; step();
    din = 8'h01; wr_en = 1'b1; step();
    din = 8'h02; step();
    wr_en = 1'b0;
    tick_en = 1'b1;
    ticks = 0; n = 0;
    while (ticks < 72 && n < 1000) begin
      step(); n++;
      if (s_tick) ticks++;
    end
    checks++;
    if ({tx, tx_busy, hold_full, overflow_err} !== 4'b0111) begin errors++; $display("FAIL rst_pre: got %b expected 0111", {tx, tx_busy, hold_full, overflow_err}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, tx_busy, hold_full, tx_done_tick, overflow_err} !== 5'b10000) begin
      errors++;
      $display("FAIL rst_async: got %b expected 10000", {tx, tx_busy, hold_full, tx_done_tick, overflow_err});
    end
    step(); step();
    rst_n = 1'b1;
    repeat (100) step();
    checks++;
    if ({tx, tx_busy, hold_full} !== 3'b100) begin errors++; $display("FAIL rst_no_resume: got %b expected 100", {tx, tx_busy, hold_full}); end
    din = 8'h4B; wr_en = 1'b1; step();
    wr_en = 1'b0;
    capture_frame(bits, ticks, dclk, busy_ok, tmo);
    checks++;
    if (bits !== {1'b1, 8'h4B, 1'b0} || ticks !== 160 || tmo) begin errors++; $display("FAIL rst_new_frame: got %b/%0d expected %b/160", bits, ticks, {1'b1, 8'h4B, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_drain_collision();
    test_two_stop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
